port_link: RTL and testbench
============================

// Module: port_link
// PURPOSE
//  Host-side responder for the slug CPU's 32-bit port pair: drives port_in, consumes port_out.
//  Converts the CPU's nibble-written toggle handshake into valid/ready byte streams, buffered by one FIFO per direction.
//  Sits at top level beside the slug core; software on the core exchanges bytes with the outside world through it.
// PARAMETERS
//  DEPTH  4  entries per FIFO; power of 2, >=2
//  AW     $clog2(DEPTH)  FIFO pointer width; derived, not overridden
// PORTS
//  clk       in   1   single clock, shared with slug core
//  rst       in   1   synchronous reset, active-high
//  port_out  in   32  CPU output port: [7:0] tx byte, [8] tx_req toggle, [9] rx_ack toggle, rest ignored
//  port_in   out  32  CPU input port: [7:0] rx byte, [8] tx_ack toggle, [9] rx_req toggle, [10] tx_full, [11] rx_nempty, [31:12]=0
//  m_data    out  8   byte from CPU toward host
//  m_valid   out  1   m_data valid; transfer when m_valid&m_ready
//  m_ready   in   1   host accepts m_data
//  s_data    in   8   byte from host toward CPU
//  s_valid   in   1   s_data valid
//  s_ready   out  1   = !rx_full; transfer when s_valid&s_ready
// BEHAVIOUR
//  Reset: both FIFOs empty, all port_in bits 0, m_valid=0, s_ready=1.
//  CPU->host: pending when port_out[8]!=tx_ack. Each cycle pending && !tx_full: push port_out[7:0], tx_ack<=port_out[8].
//   Ack visible 1 cycle after toggle; pending && tx_full: ack withheld, byte not lost, CPU polls.
//   Software writes byte nibbles before the toggle nibble; block samples byte only in push cycle.
//  m_valid=!tx_empty, m_data=tx head (combinational read); pop on m_valid&m_ready.
//  Host->CPU: s_valid&s_ready pushes s_data into RX FIFO.
//   rx_busy = port_in[9]!=port_out[9]. Cycle with !rx_busy && !rx_empty: pop, port_in[7:0]<=head, flip port_in[9].
//   port_in[7:0] held until next pop. CPU consumes by copying port_in[9] to port_out[9]; next byte presented 1 cycle later.
//  Simultaneous push+pop on a FIFO: both occur, count unchanged, legal even when full; pop on empty ignored.
//  Pointers wrap mod DEPTH; count is AW+1 bits, full=count==DEPTH.
//  port_in[10]=tx_full, port_in[11]=!rx_empty, combinational from counts.
//  Reset mid-operation: FIFO contents dropped, toggles to 0; in-flight CPU handshake restarts from toggles=0
//   (core resets on same rst, so port_out also returns to 0).
// CONFIGURATION
//  PORT_LINK_LOOPBACK_EN defined: TX FIFO head feeds RX FIFO push (pop when !rx_full);
//   m_valid=0, s_ready=0, m_ready/s_* ignored; CPU reads back its own bytes in order.
//  Undefined: streams as above, no loopback path.
// STRUCTURE
//  Package slug_port_pkg: bit-index localparams (TX_REQ_BIT=8, RX_ACK_BIT=9, TX_ACK_BIT=8, RX_REQ_BIT=9, TX_FULL_BIT=10, RX_NEMPTY_BIT=11), byte_t typedef.
//  Sub-module byte_fifo #(DEPTH): sync-reset circular buffer, push/pop/full/empty/count/head;
//   instantiated twice (tx_fifo, rx_fifo). Toggle FSMs live in port_link.
// TESTING
//  1 CPU send: port_out[7:0]=8'hA5, flip [8] 0->1 -> port_in[8]=1 next cycle; m_valid=1, m_data=A5; m_ready pop -> m_valid=0.
//  2 TX backpressure: m_ready=0, send DEPTH+1 bytes 01..05 -> 5th ack withheld, port_in[10]=1;
//    m_ready=1 -> ack flips, host sees 01..05 in order.
//  3 Host send: s_data=3C,7E back-to-back -> port_in[7:0]=3C, [9]=1, [11]=1; port_out[9]=1 -> next cycle port_in=7E, [9]=0.
//  4 RX full: CPU never acks, push DEPTH+1 bytes -> s_ready=0 after DEPTH in FIFO + 1 presented; ack drains in order.
//  5 Reset mid-transfer: 2 bytes in each FIFO, rst 1 cycle -> port_in=0, m_valid=0, s_ready=1, no stale byte after.
//  6 PORT_LINK_LOOPBACK_EN: CPU sends 11,22,33 -> port_in[7:0] presents 11,22,33 with acks; m_valid stays 0.

Source files
------------

// File: rtl/slug_port_pkg.sv
// slug_port_pkg: port bit positions and byte type shared by port_link and its FIFOs
package slug_port_pkg;
  localparam int TX_REQ_BIT    = 8;
  localparam int RX_ACK_BIT    = 9;
  localparam int TX_ACK_BIT    = 8;
  localparam int RX_REQ_BIT    = 9;
  localparam int TX_FULL_BIT   = 10;
  localparam int RX_NEMPTY_BIT = 11;
  typedef logic [7:0] byte_t;
endpackage

// File: rtl/port_link_if.sv
// port_link_if: CPU port pair plus host byte streams; slave side is the port_link responder
interface port_link_if;
  import slug_port_pkg::*;
  logic [31:0] port_out;
  logic [31:0] port_in;
  byte_t       m_data;
  logic        m_valid;
  logic        m_ready;
  byte_t       s_data;
  logic        s_valid;
  logic        s_ready;
  modport slave (input port_out, m_ready, s_data, s_valid, output port_in, m_data, m_valid, s_ready);
  modport master (output port_out, m_ready, s_data, s_valid, input port_in, m_data, m_valid, s_ready);
endinterface

// File: rtl/port_link_fifo.sv
// byte_fifo: sync-reset circular byte buffer; push on full is accepted only alongside a pop
module byte_fifo
  import slug_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  byte_t                  data_i,
  input  logic                   pop_i,
  output byte_t                  head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  byte_t         mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;
  assign empty_o = cnt_q == '0;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  // qualify requests and advance pointers/count
  always_comb begin
    do_pop  = pop_i && !empty_o;
    do_push = push_i && (!full_o || do_pop);
    wr_d    = do_push ? wr_q + 1'b1 : wr_q;
    rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d   = (do_push && !do_pop) ? cnt_q + 1'b1 : (do_pop && !do_push) ? cnt_q - 1'b1 : cnt_q;
  end
  // pointer and count registers; reset empties the buffer without clearing storage
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage write
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/port_link.sv
// port_link: slug CPU port-pair responder bridging toggle handshakes to byte streams; PORT_LINK_LOOPBACK_EN routes TX back to RX
module port_link
  import slug_port_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  port_link_if.slave    link_io
);
  localparam int AW = $clog2(DEPTH);
  logic          tx_ack_q, tx_ack_d, rx_req_q, rx_req_d;
  byte_t         rx_byte_q, rx_byte_d;
  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic          rx_push, rx_pop, rx_full, rx_empty;
  byte_t         tx_head, rx_head, rx_data;
  logic [AW:0]   tx_count_unused, rx_count_unused;
  logic [21:0]   port_out_unused;
  assign port_out_unused = link_io.port_out[31:10];
`ifdef PORT_LINK_LOOPBACK_EN
  logic [9:0]    host_unused;
  assign host_unused    = {link_io.m_ready, link_io.s_valid, link_io.s_data};
  assign tx_pop         = !tx_empty && !rx_full;
  assign rx_push        = tx_pop;
  assign rx_data        = tx_head;
  assign link_io.m_valid = 1'b0;
  assign link_io.s_ready = 1'b0;
`else
  assign tx_pop         = !tx_empty && link_io.m_ready;
  assign rx_push        = link_io.s_valid && !rx_full;
  assign rx_data        = link_io.s_data;
  assign link_io.m_valid = !tx_empty;
  assign link_io.s_ready = !rx_full;
`endif
  assign link_io.m_data = tx_head;
  // toggle handshakes: accept a CPU byte when the request toggle differs and TX has room; present an RX byte when the CPU has caught up
  always_comb begin
    tx_push   = (link_io.port_out[TX_REQ_BIT] != tx_ack_q) && !tx_full;
    tx_ack_d  = tx_push ? link_io.port_out[TX_REQ_BIT] : tx_ack_q;
    rx_pop    = (rx_req_q == link_io.port_out[RX_ACK_BIT]) && !rx_empty;
    rx_req_d  = rx_pop ? !rx_req_q : rx_req_q;
    rx_byte_d = rx_pop ? rx_head : rx_byte_q;
  end
  // handshake state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_ack_q  <= 1'b0;
      rx_req_q  <= 1'b0;
      rx_byte_q <= '0;
    end else begin
      tx_ack_q  <= tx_ack_d;
      rx_req_q  <= rx_req_d;
      rx_byte_q <= rx_byte_d;
    end
  end
  // CPU input port image
  always_comb begin
    link_io.port_in                = '0;
    link_io.port_in[7:0]           = rx_byte_q;
    link_io.port_in[TX_ACK_BIT]    = tx_ack_q;
    link_io.port_in[RX_REQ_BIT]    = rx_req_q;
    link_io.port_in[TX_FULL_BIT]   = tx_full;
    link_io.port_in[RX_NEMPTY_BIT] = !rx_empty;
  end
  byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .clk(clk), .rst(rst), .push_i(tx_push), .data_i(link_io.port_out[7:0]), .pop_i(tx_pop),
    .head_o(tx_head), .full_o(tx_full), .empty_o(tx_empty), .count_o(tx_count_unused)
  );
  byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .clk(clk), .rst(rst), .push_i(rx_push), .data_i(rx_data), .pop_i(rx_pop),
    .head_o(rx_head), .full_o(rx_full), .empty_o(rx_empty), .count_o(rx_count_unused)
  );
endmodule

// File: tb/tb_port_link.sv
// tb_port_link: directed checks of port_link handshakes, backpressure and reset
module tb_port_link;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  port_link_if link ();
  port_link #(.DEPTH(4)) dut (.clk(clk), .rst(rst), .link_io(link));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_tx(input logic [7:0] b);
    link.port_out[7:0] = b;
    link.port_out[8]   = ~link.port_out[8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (link.port_in !== 32'h0) begin n_fail++; $display("FAIL reset_port_in got %h want 00000000", link.port_in); end
    n_checks++; if (link.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid got %b want 0", link.m_valid); end
    n_checks++; if (link.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready got %b want 1", link.s_ready); end
  endtask

  task automatic test_cpu_send();
    send_tx(8'hA5);
    n_checks++; if (link.port_in[8] !== 1'b0) begin n_fail++; $display("FAIL send_ack_early got %b want 0", link.port_in[8]); end
    tick();
    n_checks++; if (link.port_in[8] !== 1'b1) begin n_fail++; $display("FAIL send_ack got %b want 1", link.port_in[8]); end
    n_checks++; if (link.m_valid !== 1'b1) begin n_fail++; $display("FAIL send_m_valid got %b want 1", link.m_valid); end
    n_checks++; if (link.m_data !== 8'hA5) begin n_fail++; $display("FAIL send_m_data got %h want a5", link.m_data); end
    link.m_ready = 1'b1;
    tick();
    link.m_ready = 1'b0;
    n_checks++; if (link.m_valid !== 1'b0) begin n_fail++; $display("FAIL send_pop_m_valid got %b want 0", link.m_valid); end
  endtask

  task automatic test_tx_backpressure();
    logic [7:0] got[$];
    for (int i = 1; i <= 5; i++) begin
      send_tx(8'(i));
      tick();
      if (i <= 4) begin
        n_checks++; if (link.port_in[8] !== link.port_out[8]) begin n_fail++; $display("FAIL bp_ack_%0d got %b want %b", i, link.port_in[8], link.port_out[8]); end
      end
    end
    tick();
    n_checks++; if (link.port_in[8] !== ~link.port_out[8]) begin n_fail++; $display("FAIL bp_ack_withheld got %b want %b", link.port_in[8], ~link.port_out[8]); end
    n_checks++; if (link.port_in[10] !== 1'b1) begin n_fail++; $display("FAIL bp_tx_full got %b want 1", link.port_in[10]); end
    link.m_ready = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (link.m_valid) got.push_back(link.m_data);
      tick();
    end
    link.m_ready = 1'b0;
    n_checks++; if (got.size() !== 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", got.size()); end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= got.size() || got[k] !== 8'(k + 1)) begin
        n_fail++;
        $display("FAIL bp_order_%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, 8'(k + 1));
      end
    end
    n_checks++; if (link.port_in[8] !== link.port_out[8]) begin n_fail++; $display("FAIL bp_ack_late got %b want %b", link.port_in[8], link.port_out[8]); end
    n_checks++; if (link.port_in[10] !== 1'b0) begin n_fail++; $display("FAIL bp_tx_full_clr got %b want 0", link.port_in[10]); end
  endtask

  task automatic test_host_send();
    link.s_valid = 1'b1;
    link.s_data  = 8'h3C;
    tick();
    link.s_data  = 8'h7E;
    tick();
    link.s_valid = 1'b0;
    n_checks++; if (link.port_in[7:0] !== 8'h3C) begin n_fail++; $display("FAIL host_byte0 got %h want 3c", link.port_in[7:0]); end
    n_checks++; if (link.port_in[9] !== 1'b1) begin n_fail++; $display("FAIL host_req0 got %b want 1", link.port_in[9]); end
    n_checks++; if (link.port_in[11] !== 1'b1) begin n_fail++; $display("FAIL host_nempty0 got %b want 1", link.port_in[11]); end
    link.port_out[9] = 1'b1;
    tick();
    n_checks++; if (link.port_in[7:0] !== 8'h7E) begin n_fail++; $display("FAIL host_byte1 got %h want 7e", link.port_in[7:0]); end
    n_checks++; if (link.port_in[9] !== 1'b0) begin n_fail++; $display("FAIL host_req1 got %b want 0", link.port_in[9]); end
    n_checks++; if (link.port_in[11] !== 1'b0) begin n_fail++; $display("FAIL host_nempty1 got %b want 0", link.port_in[11]); end
    link.port_out[9] = 1'b0;
    tick();
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < 5; i++) begin
      link.s_valid = 1'b1;
      link.s_data  = 8'h41 + 8'(i);
      n_checks++; if (link.s_ready !== 1'b1) begin n_fail++; $display("FAIL rxf_ready_%0d got %b want 1", i, link.s_ready); end
      tick();
    end
    link.s_data = 8'h46;
    tick();
    link.s_valid = 1'b0;
    n_checks++; if (link.s_ready !== 1'b0) begin n_fail++; $display("FAIL rxf_ready_full got %b want 0", link.s_ready); end
    n_checks++; if (link.port_in[11] !== 1'b1) begin n_fail++; $display("FAIL rxf_nempty got %b want 1", link.port_in[11]); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (link.port_in[7:0] !== 8'h41 + 8'(k)) begin n_fail++; $display("FAIL rxf_byte_%0d got %h want %h", k, link.port_in[7:0], 8'h41 + 8'(k)); end
      n_checks++; if (link.port_in[9] === link.port_out[9]) begin n_fail++; $display("FAIL rxf_req_%0d got %b want %b", k, link.port_in[9], ~link.port_out[9]); end
      link.port_out[9] = ~link.port_out[9];
      tick();
    end
    n_checks++; if (link.port_in[11] !== 1'b0) begin n_fail++; $display("FAIL rxf_drained got %b want 0", link.port_in[11]); end
    n_checks++; if (link.s_ready !== 1'b1) begin n_fail++; $display("FAIL rxf_ready_after got %b want 1", link.s_ready); end
    n_checks++; if (link.port_in[9] !== link.port_out[9]) begin n_fail++; $display("FAIL rxf_idle_req got %b want %b", link.port_in[9], link.port_out[9]); end
  endtask

  task automatic test_reset_mid();
    send_tx(8'hAA);
    tick();
    send_tx(8'hBB);
    tick();
    link.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      link.s_data = 8'hC1 + 8'(i);
      tick();
    end
    link.s_valid = 1'b0;
    n_checks++; if (link.m_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_m_valid got %b want 1", link.m_valid); end
    n_checks++; if (link.port_in[11] !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_nempty got %b want 1", link.port_in[11]); end
    rst = 1'b1;
    link.port_out = '0;
    tick();
    rst = 1'b0;
    n_checks++; if (link.port_in !== 32'h0) begin n_fail++; $display("FAIL rmid_port_in got %h want 00000000", link.port_in); end
    n_checks++; if (link.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_m_valid got %b want 0", link.m_valid); end
    n_checks++; if (link.s_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_s_ready got %b want 1", link.s_ready); end
    tick();
    tick();
    n_checks++; if (link.port_in !== 32'h0) begin n_fail++; $display("FAIL rmid_stale_port_in got %h want 00000000", link.port_in); end
    n_checks++; if (link.m_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale_m_valid got %b want 0", link.m_valid); end
  endtask

`ifdef PORT_LINK_LOOPBACK_EN
  task automatic test_loopback();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h11;
    exp_b[1] = 8'h22;
    exp_b[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      send_tx(exp_b[i]);
      tick();
      n_checks++; if (link.port_in[8] !== link.port_out[8]) begin n_fail++; $display("FAIL lb_ack_%0d got %b want %b", i, link.port_in[8], link.port_out[8]); end
    end
    n_checks++; if (link.s_ready !== 1'b0) begin n_fail++; $display("FAIL lb_s_ready got %b want 0", link.s_ready); end
    for (int k = 0; k < 3; k++) begin
      int w = 0;
      while (link.port_in[9] === link.port_out[9] && w < 10) begin
        tick();
        w++;
      end
      n_checks++; if (w >= 10) begin n_fail++; $display("FAIL lb_timeout_%0d got no byte want byte within 10 cycles", k); end
      n_checks++; if (link.port_in[7:0] !== exp_b[k]) begin n_fail++; $display("FAIL lb_byte_%0d got %h want %h", k, link.port_in[7:0], exp_b[k]); end
      n_checks++; if (link.m_valid !== 1'b0) begin n_fail++; $display("FAIL lb_m_valid_%0d got %b want 0", k, link.m_valid); end
      link.port_out[9] = ~link.port_out[9];
      tick();
    end
  endtask
`endif

  initial begin
    link.port_out = '0;
    link.m_ready  = 1'b0;
    link.s_data   = '0;
    link.s_valid  = 1'b0;
    test_reset();
`ifdef PORT_LINK_LOOPBACK_EN
    test_loopback();
`else
    test_cpu_send();
    test_tx_backpressure();
    test_host_send();
    test_rx_full();
    test_reset_mid();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
